// File: rtl/pwm_audio_out.sv
// pwm_audio_out
//   Turns the mixer's 8-bit level into a 1-bit audio stream for an external
//   RC filter. The level is latched once per 256-tick frame so it never
//   changes mid-period. The modulation is either classic PWM or first-order
//   sigma-delta (PDM). A 4-bit prescaler sets the tick rate.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_in    mixer level (0 = silence, 255 = maximum)
//   enable       1 = modulator running; 0 = idle, output forced low
//   mode         0 = PWM, 1 = sigma-delta; takes effect at a frame boundary
//   prescale     one tick every (prescale+1) clocks
//   pwm_out      registered 1-bit audio output
//   frame_start  one-clock pulse when a new sample and mode are latched
//   sample_held  sample currently being modulated
module pwm_audio_out (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       enable,
    input  logic       mode,
    input  logic [3:0] prescale,
    output logic       pwm_out,
    output logic       frame_start,
    output logic [7:0] sample_held
);

    logic [3:0] div_cnt;
    logic [7:0] phase;
    logic [7:0] acc;
    logic       mode_active;

    logic       tick;
    logic       boundary;
    logic [8:0] sum;

    // The >= compare means that lowering prescale below the current count
    // gives a tick on the next clock. An == compare would let the counter
    // run on through a full 16-clock wrap.
    assign tick     = enable && (div_cnt >= prescale);
    assign boundary = tick && (phase == 8'hFF);
    assign sum      = {1'b0, acc} + {1'b0, sample_held};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= 4'd0;
            phase       <= 8'd0;
            acc         <= 8'd0;
            mode_active <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            sample_held <= 8'd0;
        end else if (!enable) begin
            // While idle, track the inputs continuously. The first frame
            // after enable then uses the current level, not a stale one.
            div_cnt     <= 4'd0;
            phase       <= 8'd0;
            acc         <= 8'd0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            sample_held <= sample_in;
            mode_active <= mode;
        end else begin
            frame_start <= boundary;

            if (tick) begin
                div_cnt <= 4'd0;
                phase   <= phase + 8'd1;
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end

            // The boundary tick still modulates with the outgoing sample
            // and mode. The new ones apply from the following tick.
            if (!mode_active) begin
                pwm_out <= (phase < sample_held);
            end else if (tick) begin
                pwm_out <= sum[8];
                acc     <= sum[7:0];
            end

            if (boundary) begin
                sample_held <= sample_in;
                mode_active <= mode;
                // A new modulation scheme starts from a clean accumulator.
                // The same scheme keeps its residual error across frames.
                if (mode != mode_active) begin
                    acc <= 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out
//   Testbench for pwm_audio_out.
//   - A reference model predicts every output on every clock.
//   - A frame monitor checks frame length and high-count per frame against
//     figures derived directly from the sample level.
//   - Directed scenarios come first, then a randomized soak.
module tb_pwm_audio_out;

    logic       clk;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       enable;
    logic       mode;
    logic [3:0] prescale;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] sample_held;

    int checks;
    int failures;

    pwm_audio_out dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .enable      (enable),
        .mode        (mode),
        .prescale    (prescale),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .sample_held (sample_held)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Integer bookkeeping of the tick counter, frame position and the
    // sigma-delta running sum. A carry is emitted whenever the sum crosses 256.
    int m_cnt, m_phase, m_acc, m_held;
    bit m_sd, m_out, m_fs, m_tick, m_bnd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_phase = 0; m_acc = 0; m_held = 0;
            m_sd = 0; m_out = 0; m_fs = 0;
        end else if (!enable) begin
            m_cnt = 0; m_phase = 0; m_acc = 0; m_out = 0; m_fs = 0;
            m_held = int'(sample_in);
            m_sd = mode;
        end else begin
            m_tick = (m_cnt >= int'(prescale));
            m_bnd  = m_tick && (m_phase == 255);
            if (!m_sd) begin
                m_out = (m_phase < m_held);
            end else if (m_tick) begin
                m_acc = m_acc + m_held;
                m_out = (m_acc >= 256);
                m_acc = m_acc % 256;
            end
            m_fs = m_bnd;
            if (m_bnd) begin
                if (mode != m_sd) m_acc = 0;
                m_held = int'(sample_in);
                m_sd = mode;
            end
            m_cnt = m_tick ? 0 : m_cnt + 1;
            if (m_tick) m_phase = (m_phase + 1) % 256;
        end
    end

    always @(negedge clk) begin
        check_eq("cycle", {22'd0, pwm_out, frame_start, sample_held},
                 {22'd0, m_out, m_fs, m_held[7:0]});
    end

    // ---------------- frame monitor ----------------
    // The window runs from the clock after one frame_start up to and
    // including the next frame_start. Over that window:
    //   high count = level * (prescale+1)
    //   length     = 256 * (prescale+1)
    // The first window after any configuration change is skipped.
    bit stat_on;
    int stat_exp;
    int cfg_gen, seen_gen;
    int hi_cnt, len_cnt;

    always @(negedge clk) begin
        hi_cnt  += int'(pwm_out);
        len_cnt += 1;
        if (frame_start) begin
            if (stat_on && cfg_gen == seen_gen) begin
                check_eq("frame_hi", hi_cnt, stat_exp);
                check_eq("frame_len", len_cnt, 256 * (int'(prescale) + 1));
            end
            seen_gen = cfg_gen;
            hi_cnt = 0;
            len_cnt = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input bit en, input bit md, input int ps, input int smp,
                           input bit st, input int exp_hi);
        enable    = en;
        mode      = md;
        prescale  = 4'(ps);
        sample_in = 8'(smp);
        stat_on   = st;
        stat_exp  = exp_hi;
        cfg_gen++;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < bound);
        if (!frame_start) check_eq("fs_timeout", n, 0);
    endtask

    // ---------------- stimulus ----------------
    int n;

    initial begin
        checks = 0; failures = 0;
        cfg_gen = 0; seen_gen = 0; hi_cnt = 0; len_cnt = 0;
        stat_on = 0; stat_exp = 0;
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; prescale = 4'd0; sample_in = 8'd0;
        run(2);
        check_eq("rst_outputs", {22'd0, pwm_out, frame_start, sample_held}, 32'd0);
        rst_n = 1'b1;

        // Idle: sample tracked continuously, output low.
        set_cfg(0, 0, 0, 64, 0, 0);
        run(3);
        check_eq("idle_held", sample_held, 64);
        check_eq("idle_out", pwm_out, 0);

        // PWM, level 64, prescale 0.
        set_cfg(1, 0, 0, 64, 1, 64);
        run(256 * 3 + 10);

        // PWM, level 192, prescale 3.
        set_cfg(1, 0, 3, 192, 1, 192 * 4);
        run(1024 * 3 + 10);

        // Reduce prescale 3 -> 1 mid-frame.
        set_cfg(1, 0, 3, 100, 0, 0);
        run(300 + $urandom_range(0, 3));
        prescale = 4'd1;
        run(1200);

        // PWM extremes.
        set_cfg(1, 0, 0, 0, 1, 0);
        run(256 * 3);
        set_cfg(1, 0, 0, 255, 1, 255);
        run(256 * 3);

        // Sigma-delta densities.
        set_cfg(1, 1, 0, 128, 1, 128);
        run(256 * 3);
        set_cfg(1, 1, 0, 64, 1, 64);
        run(256 * 3);

        // Change level and mode at phase 100.
        set_cfg(1, 0, 0, 32, 1, 32);
        wait_fs(600, n);
        run(256 + 100 - 1);
        set_cfg(1, 1, 0, 200, 1, 200);
        run(256 * 3);

        // Randomized soak.
        set_cfg(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 120; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            mode      = 1'($urandom_range(0, 1));
            prescale  = 4'($urandom_range(0, 15));
            sample_in = 8'($urandom);
            run($urandom_range(1, 300));
        end

        // Asynchronous reset while pwm_out is high.
        set_cfg(1, 0, 0, 128, 0, 0);
        n = 0;
        while (!pwm_out && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq("pre_rst_high", pwm_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_out", pwm_out, 0);
        check_eq("async_rst_fs", frame_start, 0);
        check_eq("async_rst_held", sample_held, 0);
        run(2);
        rst_n = 1'b1;
        wait_fs(1000, n);
        check_eq("rst_first_fs", n, 256);
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
